// File: rtl/mem_writer.sv
// rtl/mem_writer.sv - stream-to-RAM loader writing consecutive words; define MEM_WRITER_VERIFY_EN for readback verify
module mem_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE,
    input  logic [ADDR_W:0]   COUNT,
    input  logic              VALID,
    input  logic [DATA_W-1:0] DIN,
    output logic              READY,
    output logic              WE,
    output logic [ADDR_W-1:0] WA,
    output logic [DATA_W-1:0] WD,
    output logic              BUSY,
    output logic              DONE
`ifdef MEM_WRITER_VERIFY_EN
    ,
    output logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] RD,
    output logic              ERR,
    output logic [ADDR_W-1:0] ERR_ADR
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DONE  = 3'd2;
`ifdef MEM_WRITER_VERIFY_EN
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
`endif

    localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   rem;
    logic              hs;

    assign READY = (state == S_LOAD);
    assign hs    = VALID & READY;
    assign DONE  = (state == S_DONE);
`ifdef MEM_WRITER_VERIFY_EN
    assign BUSY  = (state == S_LOAD) || (state == S_WRITE) || (state == S_CHECK);
`else
    assign BUSY  = (state == S_LOAD);
`endif

    // WA/WD only move on a handshake, so they hold between writes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            addr  <= '0;
            rem   <= '0;
            WE    <= 1'b0;
            WA    <= '0;
            WD    <= '0;
        end else begin
            WE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        addr  <= BASE;
                        rem   <= COUNT;
                        state <= (COUNT == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        WE   <= 1'b1;
                        WA   <= addr;
                        WD   <= DIN;
                        addr <= addr + 1'b1;
                        rem  <= rem - 1'b1;
`ifdef MEM_WRITER_VERIFY_EN
                        state <= S_WRITE;
`else
                        if (rem == REM_ONE)
                            state <= S_DONE;
`endif
                    end
                end
`ifdef MEM_WRITER_VERIFY_EN
                S_WRITE: state <= S_CHECK;
                // rem was already decremented on the handshake.
                S_CHECK: state <= (rem == '0) ? S_DONE : S_LOAD;
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_WRITER_VERIFY_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            A       <= '0;
            ERR     <= 1'b0;
            ERR_ADR <= '0;
        end else begin
            if (state == S_IDLE && START) begin
                ERR     <= 1'b0;
                ERR_ADR <= '0;
            end
            if (state == S_WRITE)
                A <= WA;
            // Only the first mismatching address is kept.
            if (state == S_CHECK && RD != WD) begin
                ERR <= 1'b1;
                if (!ERR)
                    ERR_ADR <= WA;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_writer.sv
// tb/tb_mem_writer.sv - randomized bench for mem_writer against a transfer-level reference model
module tb_mem_writer;

`ifdef MEM_WRITER_VERIFY_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        CLK;
    logic        RST;
    logic        START;
    logic [7:0]  BASE;
    logic [8:0]  COUNT;
    logic        VALID;
    logic [31:0] DIN;
    logic        READY;
    logic        WE;
    logic [7:0]  WA;
    logic [31:0] WD;
    logic        BUSY;
    logic        DONE;
`ifdef MEM_WRITER_VERIFY_EN
    logic [7:0]  A;
    logic [31:0] RD;
    logic        ERR;
    logic [7:0]  ERR_ADR;
`endif

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    int          bad_adr;
    int          checks;
    int          errors;
    logic [7:0]  last_wa;
    logic [31:0] last_wd;
    logic [7:0]  exp_a [$];
    logic [31:0] exp_d [$];

    mem_writer #(.DATA_W(32), .ADDR_W(8)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .COUNT(COUNT),
        .VALID(VALID), .DIN(DIN), .READY(READY), .WE(WE), .WA(WA), .WD(WD),
        .BUSY(BUSY), .DONE(DONE)
`ifdef MEM_WRITER_VERIFY_EN
        , .A(A), .RD(RD), .ERR(ERR), .ERR_ADR(ERR_ADR)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM model; bad_adr lets a test corrupt bit 0 of one location.
    always @(posedge CLK)
        if (WE)
            mem[WA] <= (int'(WA) == bad_adr) ? (WD ^ 32'h1) : WD;
`ifdef MEM_WRITER_VERIFY_EN
    assign RD = mem[A];
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transfer; the model tracks words sent, cycles since the last handshake
    // and the ready-blocking cooldown, and predicts every output each cycle.
    task automatic xfer(input logic [7:0] base, input int count, input int vprob,
                        input bit seq, input bit poke);
        int sent = 0, t = 0, cool = 0, since = 0;
        bit hs_prev = 0, hs, finished = 0, er, ed, eb;
        logic [31:0] w;
        logic [7:0]  a;
        exp_a.delete();
        exp_d.delete();
        START = 1'b1; BASE = base; COUNT = 9'(count); VALID = 1'($urandom_range(1));
        @(negedge CLK);
        START = 1'b0;
        while (!finished) begin
            t++;
            if (hs_prev) begin
                cool = LAT - 1; since = 1;
            end else begin
                if (cool > 0) cool--;
                if (since < 100) since++;
            end
            er = (count != 0) && (sent < count) && (cool == 0);
            ed = (count == 0) ? (t == 1) : (sent == count && since == LAT);
            eb = (count != 0) && !(sent == count && since >= LAT);
            chk("ready", READY, er);
            chk("busy", BUSY, eb);
            chk("done", DONE, ed);
            chk("we", WE, hs_prev);
            if (WE && exp_a.size() > 0) begin
                last_wa = exp_a.pop_front();
                last_wd = exp_d.pop_front();
            end
            chk("wa", WA, last_wa);
            chk("wd", WD, last_wd);
`ifdef MEM_WRITER_VERIFY_EN
            if (t == 1) chk("err_clear", ERR, 1'b0);
`endif
            if (ed) begin
                finished = 1;
            end else if (t >= 3000) begin
                chk("done_timeout", DONE, 1'b1);
                finished = 1;
            end else begin
                VALID = ($urandom_range(99) < vprob);
                w = seq ? (32'hA000_0000 + 32'(sent)) : $urandom;
                DIN = w;
                if (poke && $urandom_range(7) == 0) begin
                    START = 1'b1; BASE = 8'($urandom); COUNT = 9'($urandom);
                end else begin
                    START = 1'b0;
                end
                hs = VALID && er;
                if (hs) begin
                    a = base + 8'(sent);
                    exp_a.push_back(a);
                    exp_d.push_back(w);
                    ref_mem[a] = w;
                    sent++;
                end
                hs_prev = hs;
                @(negedge CLK);
            end
        end
        START = 1'b0;
        VALID = 1'($urandom_range(1));
        @(negedge CLK);
        chk("idle_ready", READY, 1'b0);
        chk("idle_busy", BUSY, 1'b0);
        chk("idle_done", DONE, 1'b0);
        chk("idle_we", WE, 1'b0);
    endtask

    initial begin
        int n, k, nbad;
        checks = 0; errors = 0; bad_adr = -1;
        last_wa = '0; last_wd = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0; ref_mem[i] = '0;
        end
        RST = 1'b1; START = 1'b0; BASE = '0; COUNT = '0; VALID = 1'b1; DIN = 32'hFFFF_FFFF;

        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_ready", READY, 1'b0);
            chk("rst_we", WE, 1'b0);
            chk("rst_busy", BUSY, 1'b0);
            chk("rst_done", DONE, 1'b0);
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("post_rst_we", WE, 1'b0);
            chk("post_rst_ready", READY, 1'b0);
            chk("post_rst_wa", WA, 8'h00);
        end

        xfer(8'h00, 4, 100, 1'b1, 1'b0);
        xfer(8'hFE, 3, 100, 1'b0, 1'b0);
        xfer(8'h00, 0, 100, 1'b0, 1'b0);
        xfer(8'h30, 3, 40, 1'b0, 1'b1);

        // Abort after two of five words.
        START = 1'b1; BASE = 8'h20; COUNT = 9'd5; VALID = 1'b1; DIN = 32'hC0DE_5A5A;
        @(negedge CLK);
        START = 1'b0;
        n = 0; k = 0;
        while (n < 2 && k < 30) begin
            @(negedge CLK);
            k++;
            if (WE) begin
                chk("abort_wa", WA, 64'(32'h20 + n));
                chk("abort_wd", WD, 32'hC0DE_5A5A);
                n++;
            end
        end
        chk("abort_writes", n, 2);
        ref_mem[8'h20] = 32'hC0DE_5A5A;
        ref_mem[8'h21] = 32'hC0DE_5A5A;
        RST = 1'b1;
        #1;
        chk("abort_ready", READY, 1'b0);
        chk("abort_we", WE, 1'b0);
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_done", DONE, 1'b0);
        chk("abort_wa0", WA, 8'h00);
        chk("abort_wd0", WD, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        last_wa = '0; last_wd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("abort_idle_we", WE, 1'b0);
            chk("abort_idle_ready", READY, 1'b0);
        end
        xfer(8'h40, 1, 100, 1'b0, 1'b0);

        xfer(8'h10, 256, 100, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            xfer(8'($urandom), $urandom_range(1, 40), $urandom_range(20, 100), 1'b0, 1'b1);

`ifdef MEM_WRITER_VERIFY_EN
        bad_adr = 2;
        xfer(8'h00, 4, 100, 1'b1, 1'b0);
        chk("verify_err", ERR, 1'b1);
        chk("verify_err_adr", ERR_ADR, 8'h02);
        bad_adr = -1;
        xfer(8'h00, 4, 100, 1'b1, 1'b0);
        chk("verify_err_clean", ERR, 1'b0);
`endif

        nbad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) nbad++;
        chk("mem_image", nbad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
